trap_csr: RTL and testbench

TRAP_CSR -- requirements
Module: trap_csr

---
 rtl/trap_csr.sv | 185 ++++++++++++++++++
 tb/tb_trap_csr.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_csr.sv
// trap_csr: machine-mode trap and CSR unit for a single-hart core.
//   Holds mstatus (MIE/MPIE), mtvec, mscratch, mepc, mcause, mtval, the
//   mcycle/minstret 64-bit counters and a read-only mhartid. It records trap
//   state, executes MRET, and issues a one-cycle PC redirect after each.
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   controlReset        trap taken this cycle (mcause/mtval/trapPc describe it)
//   mretSignal          MRET retiring; retireValid: one instruction retired
//   csrValid/csrOp/csrWrite/csrAddress/csrWriteData   CSR access request
//   csrReadData         combinational old value of the addressed CSR
//   csrIllegal          combinational unknown address or write to mhartid
//   redirectValid/redirectPc   redirect presented the cycle after trap/MRET
//   mieOut              current mstatus.MIE
module trap_csr (
  input  logic        clock,
  input  logic        reset,
  input  logic        controlReset,
  input  logic [3:0]  mcause,
  input  logic [31:0] mtval,
  input  logic [31:0] trapPc,
  input  logic        mretSignal,
  input  logic        retireValid,
  input  logic        csrValid,
  input  logic [1:0]  csrOp,
  input  logic        csrWrite,
  input  logic [11:0] csrAddress,
  input  logic [31:0] csrWriteData,
  output logic [31:0] csrReadData,
  output logic        csrIllegal,
  output logic        redirectValid,
  output logic [31:0] redirectPc,
  output logic        mieOut
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  typedef enum logic [1:0] {IDLE, ENTER, RETURN} trapState_t;

  trapState_t  state, nextState;
  logic        mstatusMie, mstatusMpie;
  logic [31:0] mtvecReg, mscratchReg, mepcReg, mcauseReg, mtvalReg;
  logic [63:0] cycleCount, instretCount;

  logic [31:0] mstatusValue, mtvecValue, mepcValue;
  logic [31:0] readValue, writeValue;
  logic        knownAddress, writeEnable, mretTaken;

  // Low address bits are stored as written and masked on the way out, so
  // direct-mode mtvec and aligned mepc always read with bits 1:0 clear.
  assign mtvecValue   = mtvecReg & 32'hFFFF_FFFC;
  assign mepcValue    = mepcReg  & 32'hFFFF_FFFC;
  // MPP is hard-wired to machine mode.
  assign mstatusValue = {19'b0, 2'b11, 3'b0, mstatusMpie, 3'b0, mstatusMie, 3'b0};

  // NOTE: every signal driven in an always_comb gets a default first, so no
  // path through the case statement leaves it unassigned (no latch).
  always_comb begin
    readValue    = '0;
    knownAddress = 1'b1;
    case (csrAddress)
      ADDR_MSTATUS:   readValue = mstatusValue;
      ADDR_MTVEC:     readValue = mtvecValue;
      ADDR_MSCRATCH:  readValue = mscratchReg;
      ADDR_MEPC:      readValue = mepcValue;
      ADDR_MCAUSE:    readValue = mcauseReg;
      ADDR_MTVAL:     readValue = mtvalReg;
      ADDR_MCYCLE:    readValue = cycleCount[31:0];
      ADDR_MCYCLEH:   readValue = cycleCount[63:32];
      ADDR_MINSTRET:  readValue = instretCount[31:0];
      ADDR_MINSTRETH: readValue = instretCount[63:32];
      ADDR_MHARTID:   readValue = '0;
      default:        knownAddress = 1'b0;
    endcase
  end

  assign csrIllegal  = csrValid && (!knownAddress || (csrWrite && csrAddress == ADDR_MHARTID));
  assign csrReadData = csrIllegal ? 32'h0 : readValue;

  always_comb begin
    case (csrOp)
      OP_RW:   writeValue = csrWriteData;
      OP_RS:   writeValue = readValue | csrWriteData;
      OP_RC:   writeValue = readValue & ~csrWriteData;
      default: writeValue = readValue;
    endcase
  end

  // A trap in the same cycle drops the CSR write entirely.
  assign writeEnable = csrValid && csrWrite && (csrOp != 2'b00) && !csrIllegal && !controlReset;
  // MRET is honoured only from IDLE and never alongside a trap.
  assign mretTaken   = mretSignal && !controlReset && (state == IDLE);

  always_comb begin
    nextState     = IDLE;
    redirectValid = 1'b0;
    redirectPc    = '0;
    case (state)
      ENTER: begin
        redirectValid = 1'b1;
        redirectPc    = mtvecValue;
      end
      RETURN: begin
        redirectValid = 1'b1;
        redirectPc    = mepcValue;
      end
      default: ;
    endcase
    if (controlReset)   nextState = ENTER;
    else if (mretTaken) nextState = RETURN;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mstatusMie   <= 1'b0;
      mstatusMpie  <= 1'b0;
      mtvecReg     <= '0;
      mscratchReg  <= '0;
      mepcReg      <= '0;
      mcauseReg    <= '0;
      mtvalReg     <= '0;
      cycleCount   <= '0;
      instretCount <= '0;
    end else begin
      // A write to either counter half replaces it and holds the other half.
      if (writeEnable && csrAddress == ADDR_MCYCLE)       cycleCount[31:0]  <= writeValue;
      else if (writeEnable && csrAddress == ADDR_MCYCLEH) cycleCount[63:32] <= writeValue;
      else                                                cycleCount        <= cycleCount + 64'd1;

      if (writeEnable && csrAddress == ADDR_MINSTRET)       instretCount[31:0]  <= writeValue;
      else if (writeEnable && csrAddress == ADDR_MINSTRETH) instretCount[63:32] <= writeValue;
      else if (retireValid)                                 instretCount        <= instretCount + 64'd1;

      if (controlReset) begin
        mepcReg     <= trapPc;
        mcauseReg   <= {28'b0, mcause};
        mtvalReg    <= mtval;
        mstatusMpie <= mstatusMie;
        mstatusMie  <= 1'b0;
      end else begin
        // MRET owns mstatus in its cycle; a same-cycle mstatus write is lost.
        if (mretTaken) begin
          mstatusMie  <= mstatusMpie;
          mstatusMpie <= 1'b1;
        end else if (writeEnable && csrAddress == ADDR_MSTATUS) begin
          mstatusMie  <= writeValue[3];
          mstatusMpie <= writeValue[7];
        end
        if (writeEnable) begin
          case (csrAddress)
            ADDR_MTVEC:    mtvecReg    <= writeValue;
            ADDR_MSCRATCH: mscratchReg <= writeValue;
            ADDR_MEPC:     mepcReg     <= writeValue;
            ADDR_MCAUSE:   mcauseReg   <= writeValue;
            ADDR_MTVAL:    mtvalReg    <= writeValue;
            default: ;
          endcase
        end
      end
    end
  end

  assign mieOut = mstatusMie;

endmodule

// File: tb/tb_trap_csr.sv
// tb_trap_csr: directed scenarios plus randomized traffic for trap_csr.
// The driver applies one cycle of stimulus at each falling edge, predicts the
// outputs for that cycle from a behavioural model of the CSR file and pushes
// them onto a queue; the monitor pops one entry per cycle shortly afterwards
// and compares it with what the DUT presents.
module tb_trap_csr;

  logic        clock = 1'b0;
  logic        reset, controlReset, mretSignal, retireValid;
  logic        csrValid, csrWrite;
  logic [3:0]  trapCause;
  logic [31:0] trapValue, trapPc, csrWriteData;
  logic [1:0]  csrOp;
  logic [11:0] csrAddress;
  logic [31:0] csrReadData, redirectPc;
  logic        csrIllegal, redirectValid, mieOut;

  always #5 clock = ~clock;

  trap_csr dut (
    .clock(clock), .reset(reset), .controlReset(controlReset),
    .mcause(trapCause), .mtval(trapValue), .trapPc(trapPc),
    .mretSignal(mretSignal), .retireValid(retireValid),
    .csrValid(csrValid), .csrOp(csrOp), .csrWrite(csrWrite),
    .csrAddress(csrAddress), .csrWriteData(csrWriteData),
    .csrReadData(csrReadData), .csrIllegal(csrIllegal),
    .redirectValid(redirectValid), .redirectPc(redirectPc), .mieOut(mieOut)
  );

  typedef struct {
    logic        rst, trap, mret, retire, valid, wr;
    logic [3:0]  cause;
    logic [31:0] tval, tpc, wdata;
    logic [1:0]  op;
    logic [11:0] addr;
  } stim_t;

  typedef struct {
    logic [31:0] rd, rpc;
    logic        ill, rv, mie;
    string       tag;
  } exp_t;

  exp_t  expQ[$];
  stim_t cur;
  int    checks = 0;
  int    errors = 0;

  // Optional fixed expectations for directed cycles (override the model).
  logic        ovRdEn = 0, ovIllEn = 0, ovRvEn = 0;
  logic [31:0] ovRd, ovPc;
  logic        ovIll, ovRv;

  // Reference model: architectural CSR contents plus which redirect, if any,
  // is due in the coming cycle (0 none, 1 trap vector, 2 return to mepc).
  logic        mMie, mMpie;
  logic [31:0] mMtvec, mScratch, mMepc, mMcause, mMtval;
  logic [63:0] mCycle, mInstret;
  int          mPend;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic stim_t quiet();
    stim_t s;
    s = '{rst: 0, trap: 0, mret: 0, retire: 0, valid: 0, wr: 0, cause: 0,
          tval: 0, tpc: 0, wdata: 0, op: 0, addr: 0};
    return s;
  endfunction

  task automatic modelReset();
    mMie = 0; mMpie = 0; mMtvec = 0; mScratch = 0; mMepc = 0;
    mMcause = 0; mMtval = 0; mCycle = 0; mInstret = 0; mPend = 0;
  endtask

  // Returns {known, value}.
  function automatic logic [32:0] modelRead(input logic [11:0] a);
    case (a)
      12'h300: return {1'b1, 32'h1800 | (32'(mMie) << 3) | (32'(mMpie) << 7)};
      12'h305: return {1'b1, mMtvec};
      12'h340: return {1'b1, mScratch};
      12'h341: return {1'b1, mMepc};
      12'h342: return {1'b1, mMcause};
      12'h343: return {1'b1, mMtval};
      12'hB00: return {1'b1, mCycle[31:0]};
      12'hB80: return {1'b1, mCycle[63:32]};
      12'hB02: return {1'b1, mInstret[31:0]};
      12'hB82: return {1'b1, mInstret[63:32]};
      12'hF14: return {1'b1, 32'h0};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  task automatic step(input string tag);
    exp_t        e;
    logic [32:0] rdk;
    logic        illegal, we, mretTaken;
    logic [31:0] oldv, newv;
    @(negedge clock);
    reset = cur.rst; controlReset = cur.trap; trapCause = cur.cause;
    trapValue = cur.tval; trapPc = cur.tpc; mretSignal = cur.mret;
    retireValid = cur.retire; csrValid = cur.valid; csrOp = cur.op;
    csrWrite = cur.wr; csrAddress = cur.addr; csrWriteData = cur.wdata;

    rdk     = modelRead(cur.addr);
    oldv    = rdk[31:0];
    illegal = cur.valid && (!rdk[32] || (cur.wr && cur.addr == 12'hF14));
    e.rd  = illegal ? 32'h0 : oldv;
    e.ill = illegal;
    e.rv  = (mPend != 0);
    e.rpc = (mPend == 1) ? mMtvec : (mPend == 2) ? mMepc : 32'h0;
    e.mie = mMie;
    e.tag = tag;
    if (ovRdEn)  e.rd  = ovRd;
    if (ovIllEn) e.ill = ovIll;
    if (ovRvEn) begin e.rv = ovRv; e.rpc = ovPc; end
    ovRdEn = 0; ovIllEn = 0; ovRvEn = 0;
    expQ.push_back(e);

    if (cur.rst) modelReset();
    else begin
      case (cur.op)
        2'b01:   newv = cur.wdata;
        2'b10:   newv = oldv | cur.wdata;
        2'b11:   newv = oldv & ~cur.wdata;
        default: newv = oldv;
      endcase
      we        = cur.valid && cur.wr && cur.op != 2'b00 && !illegal && !cur.trap;
      mretTaken = cur.mret && !cur.trap && mPend == 0;

      if (we && cur.addr == 12'hB00)      mCycle = {mCycle[63:32], newv};
      else if (we && cur.addr == 12'hB80) mCycle = {newv, mCycle[31:0]};
      else                                mCycle = mCycle + 1;
      if (we && cur.addr == 12'hB02)      mInstret = {mInstret[63:32], newv};
      else if (we && cur.addr == 12'hB82) mInstret = {newv, mInstret[31:0]};
      else if (cur.retire)                mInstret = mInstret + 1;

      if (cur.trap) begin
        mMepc = cur.tpc & ~32'h3; mMcause = {28'b0, cur.cause}; mMtval = cur.tval;
        mMpie = mMie; mMie = 0; mPend = 1;
      end else begin
        if (mretTaken) begin mMie = mMpie; mMpie = 1; end
        if (we) begin
          case (cur.addr)
            12'h300: if (!mretTaken) begin mMie = newv[3]; mMpie = newv[7]; end
            12'h305: mMtvec = newv & ~32'h3;
            12'h340: mScratch = newv;
            12'h341: mMepc = newv & ~32'h3;
            12'h342: mMcause = newv;
            12'h343: mMtval = newv;
            default: ;
          endcase
        end
        mPend = mretTaken ? 2 : 0;
      end
    end
  endtask

  task automatic expRd(input logic [31:0] v);  ovRdEn = 1; ovRd = v; endtask
  task automatic expIll(input logic v);        ovIllEn = 1; ovIll = v; endtask
  task automatic expRedirect(input logic v, input logic [31:0] pc);
    ovRvEn = 1; ovRv = v; ovPc = pc;
  endtask

  task automatic csrAccess(input logic [1:0] op, input logic wr, input logic [11:0] a,
                           input logic [31:0] wd, input string tag);
    cur = quiet(); cur.valid = 1; cur.op = op; cur.wr = wr; cur.addr = a; cur.wdata = wd;
    step(tag);
  endtask

  task automatic trapCycle(input logic [31:0] pc, input logic [3:0] c, input logic [31:0] v,
                           input string tag);
    cur = quiet(); cur.trap = 1; cur.tpc = pc; cur.cause = c; cur.tval = v;
    step(tag);
  endtask

  // Monitor: one expected entry per driven cycle, sampled mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check({e.tag, ".rdata"},    csrReadData,            e.rd);
        check({e.tag, ".illegal"},  {31'b0, csrIllegal},    {31'b0, e.ill});
        check({e.tag, ".rvalid"},   {31'b0, redirectValid}, {31'b0, e.rv});
        check({e.tag, ".rpc"},      redirectPc,             e.rpc);
        check({e.tag, ".mie"},      {31'b0, mieOut},        {31'b0, e.mie});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  localparam logic [11:0] ADDRS [13] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                         12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                         12'hF14, 12'h7C0, 12'h301};

  initial begin
    cur = quiet(); cur.rst = 1;
    reset = 1; controlReset = 0; trapCause = 0; trapValue = 0; trapPc = 0;
    mretSignal = 0; retireValid = 0; csrValid = 0; csrOp = 0; csrWrite = 0;
    csrAddress = 0; csrWriteData = 0;
    @(negedge clock);
    modelReset();
    cur = quiet();
    step("idle_after_reset");

    // Trap entry through a direct-mode vector.
    csrAccess(2'b01, 1, 12'h305, 32'h0000_0103, "wr_mtvec");
    trapCycle(32'h80, 4'h2, 32'hDEAD, "trap1");
    expRedirect(1, 32'h100); expRd(32'h80);
    csrAccess(2'b10, 0, 12'h341, 0, "enter1_mepc");
    expRedirect(0, 0); expRd(32'h2);
    csrAccess(2'b10, 0, 12'h342, 0, "rd_mcause");
    expRd(32'hDEAD);
    csrAccess(2'b10, 0, 12'h343, 0, "rd_mtval");

    // MIE set, trap stacks it, MRET restores it.
    expRd(32'h1800);
    csrAccess(2'b10, 1, 12'h300, 32'h8, "set_mie");
    expRd(32'h1808);
    csrAccess(2'b10, 0, 12'h300, 0, "rd_mstatus_mie");
    trapCycle(32'h124, 4'h3, 0, "trap2");
    expRd(32'h1880);
    csrAccess(2'b10, 0, 12'h300, 0, "enter2_mstatus");
    cur = quiet(); cur.mret = 1; step("mret");
    expRedirect(1, 32'h124); expRd(32'h1888);
    csrAccess(2'b10, 0, 12'h300, 0, "return_mstatus");

    // mcycle carry into the high word.
    csrAccess(2'b01, 1, 12'hB00, 32'hFFFF_FFFF, "wr_mcycle");
    csrAccess(2'b01, 1, 12'hB80, 32'h0, "wr_mcycleh");
    expRd(32'hFFFF_FFFF); csrAccess(2'b10, 0, 12'hB00, 0, "mcycle_held");
    expRd(32'h0);         csrAccess(2'b10, 0, 12'hB00, 0, "mcycle_wrap");
    expRd(32'h1);         csrAccess(2'b10, 0, 12'hB00, 0, "mcycle_after");
    expRd(32'h1);         csrAccess(2'b10, 0, 12'hB80, 0, "mcycleh_carry");

    // Trap beats MRET and a CSR write in the same cycle.
    csrAccess(2'b01, 1, 12'h340, 32'h1111, "wr_mscratch");
    cur = quiet(); cur.trap = 1; cur.mret = 1; cur.tpc = 32'h200; cur.cause = 4'h5;
    cur.valid = 1; cur.op = 2'b01; cur.wr = 1; cur.addr = 12'h340; cur.wdata = 32'h2222;
    step("trap_mret_write");
    expRedirect(1, 32'h100); expRd(32'h1111);
    csrAccess(2'b10, 0, 12'h340, 0, "enter3_mscratch");
    expRedirect(0, 0); expRd(32'h200);
    csrAccess(2'b10, 0, 12'h341, 0, "no_return");

    // Illegal accesses.
    expIll(1); expRd(0); csrAccess(2'b10, 0, 12'h7C0, 0, "unknown_addr");
    expIll(1); expRd(0); csrAccess(2'b01, 1, 12'hF14, 32'hFFFF_FFFF, "wr_mhartid");
    expIll(0); expRd(0); csrAccess(2'b10, 0, 12'hF14, 0, "rd_mhartid");
    expRd(32'h1111);     csrAccess(2'b10, 0, 12'h340, 0, "mscratch_kept");

    // Reset while in ENTER.
    trapCycle(32'h44, 4'h1, 32'h9, "trap4");
    cur = quiet(); cur.rst = 1; expRedirect(1, 32'h100); step("reset_in_enter");
    expRedirect(0, 0); expRd(0); csrAccess(2'b10, 0, 12'hB00, 0, "post_reset_mcycle");
    expRd(0);       csrAccess(2'b10, 0, 12'h305, 0, "post_reset_mtvec");
    expRd(0);       csrAccess(2'b10, 0, 12'h341, 0, "post_reset_mepc");
    expRd(32'h1800); csrAccess(2'b10, 0, 12'h300, 0, "post_reset_mstatus");

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cur = quiet();
      cur.rst    = ($urandom_range(0, 199) == 0);
      cur.trap   = ($urandom_range(0, 15) == 0);
      cur.mret   = ($urandom_range(0, 7) == 0);
      cur.retire = $urandom_range(0, 1);
      cur.cause  = 4'($urandom);
      cur.tval   = $urandom;
      cur.tpc    = $urandom;
      cur.valid  = ($urandom_range(0, 3) != 0);
      cur.op     = 2'($urandom);
      cur.wr     = $urandom_range(0, 1);
      cur.addr   = ADDRS[$urandom_range(0, 12)];
      cur.wdata  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                               : $urandom;
      step("random");
    end

    @(negedge clock);
    #2;
    check("queue_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
